// File: rtl/serial_frame_rx_if.sv
// Bus bundle for serial_frame_rx: the serial input pair and the
// valid/ready output buffer with its status flags.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             par_err;
    logic             overrun;

    // Receiver side: consumes the serial bits, drives the buffered word.
    modport master (
        input  din,
        input  en,
        input  dout_ready,
        output dout,
        output dout_valid,
        output par_err,
        output overrun
    );

    // Environment side: feeds serial bits, accepts words.
    modport slave (
        output din,
        output en,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  par_err,
        input  overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: hunts for a sync pattern, shifts in one word
// MSB-first, checks even parity and presents the word on a single-entry
// valid/ready buffer. A frame finishing into a full, non-draining buffer
// is dropped and flagged with a one-cycle overrun pulse.
module serial_frame_rx #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_rx_if.master bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    // Only the last SYNC_LEN-1 bits are needed; the current din completes
    // the candidate window.
    logic [SYNC_LEN-2:0] hist_q, hist_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                par_err_q, par_err_d;
    logic                overrun_q, overrun_d;

    logic [SYNC_LEN-1:0] sync_win;
    logic                drain;
    logic                perr;

    assign sync_win = {hist_q, bus.din};
    assign drain    = dout_valid_q & bus.dout_ready;
    assign perr     = ^{sh_q, bus.din};

    // Next-state logic for the framing FSM and the output buffer.
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        par_err_d    = par_err_q;
        overrun_d    = 1'b0;

        // A drain empties the buffer unless a completing frame refills it below.
        if (drain) begin
            dout_valid_d = 1'b0;
        end

        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    hist_d = sync_win[SYNC_LEN-2:0];
                    if (sync_win == SYNC_PAT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    sh_d = {sh_q[WIDTH-2:0], bus.din};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    // Clearing the history forces a full sync before every frame.
                    state_d = HUNT;
                    hist_d  = '0;
                    if (!dout_valid_q || drain) begin
                        dout_d       = sh_q;
                        par_err_d    = perr;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    hist_d  = '0;
                end
            endcase
        end
    end

    // State registers; reset discards any partial frame and the buffer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            hist_q       <= '0;
            cnt_q        <= '0;
            sh_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.overrun    = overrun_q;

endmodule
